// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with runtime framing options fed from a transmit FIFO
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [DATA_W-1:0] wr_data,
  input  logic wr_valid,
  output logic wr_ready,
  input  logic [3:0] data_bits,
  input  logic parity_en,
  input  logic parity_odd,
  input  logic two_stop,
  input  logic [DIV_W-1:0] baud_div,
  output logic TX,
  output logic busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [DATA_W-1:0] sh, sh_n, head;
  logic [3:0] n, n_c, bitc;
  logic [DIV_W-1:0] div, div_c, bcnt;
  logic par_en, par, two, tick, push, pop, tx_n, empty;
  assign empty = fifo_count == '0;
  assign wr_ready = fifo_count != FULL && !reset;
  assign push = wr_valid && wr_ready;
  assign busy = state != IDLE;
  assign n_c = data_bits < 4'd5 ? 4'd5 : data_bits > 4'(DATA_W) ? 4'(DATA_W) : data_bits;
  assign div_c = baud_div < DIV_W'(2) ? DIV_W'(2) : baud_div;
  assign tick = bcnt == div - DIV_W'(1);
  always_comb begin
    head = mem[rp];
    for (int i = 0; i < DATA_W; i++) head[i] = mem[rp][i] && 4'(i) < n_c;
  end
  always_comb begin
    state_n = state;
    pop = 1'b0;
    sh_n = sh;
    case (state)
      IDLE: if (!empty) begin
        state_n = START;
        pop = 1'b1;
      end
      START: if (tick) state_n = DATA;
      DATA: if (tick) begin
        sh_n = sh >> 1;
        if (bitc == n - 4'd1) state_n = par_en ? PARITY : STOP1;
      end
      PARITY: if (tick) state_n = STOP1;
      STOP1, STOP2: if (tick) begin
        if (state == STOP1 && two) state_n = STOP2;
        else if (!empty) begin
          state_n = START;
          pop = 1'b1;
        end else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : state_n == PARITY ? par : 1'b1;
  end
  always_ff @(posedge clk) if (push) mem[wp] <= wr_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      fifo_count <= '0;
      TX <= 1'b1;
      bcnt <= '0;
      bitc <= '0;
    end else begin
      state <= state_n;
      TX <= tx_n;
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      bcnt <= tick || state == IDLE ? '0 : bcnt + DIV_W'(1);
      bitc <= state != DATA ? '0 : tick ? bitc + 4'd1 : bitc;
      sh <= pop ? head : sh_n;
      if (pop) begin
        n <= n_c;
        div <= div_c;
        par_en <= parity_en;
        two <= two_stop;
        par <= ^head ^ parity_odd;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench comparing the serial line clock by clock against queued frames
module tb_uart_tx_fifo;
  typedef struct {
    logic [0:15] lv;
    int len;
    int div;
    bit b2b;
  } frame_t;
  logic clk, reset, wr_valid, wr_ready, parity_en, parity_odd, two_stop, TX, busy;
  logic [7:0] wr_data;
  logic [3:0] data_bits;
  logic [15:0] baud_div;
  logic [4:0] fifo_count;
  frame_t sb[$];
  int checks, failures;
  bit mon_en;
  uart_tx_fifo dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .baud_div(baud_div), .TX(TX), .busy(busy), .fifo_count(fifo_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  function automatic frame_t lit(input logic [0:15] lv, input int len, input int div, input bit b2b);
    frame_t f;
    f.lv = lv;
    f.len = len;
    f.div = div;
    f.b2b = b2b;
    return f;
  endfunction
  function automatic frame_t mk(input logic [8:0] d, input int n, input bit pen, input bit podd,
                                input int stops, input int div, input bit b2b);
    frame_t f;
    logic p;
    f.lv = '1;
    f.lv[0] = 1'b0;
    p = podd;
    for (int i = 0; i < n; i++) begin
      f.lv[1+i] = d[i];
      p ^= d[i];
    end
    if (pen) f.lv[1+n] = p;
    f.len = 1 + n + (pen ? 1 : 0) + stops;
    f.div = div;
    f.b2b = b2b;
    return f;
  endfunction
  task automatic send(input logic [7:0] d, input bit track, input frame_t f);
    int n;
    n = 0;
    wr_data = d;
    wr_valid = 1'b1;
    while (!wr_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout wr_ready got=0 expected=1");
    end else if (track) sb.push_back(f);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask
  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while ((busy || fifo_count != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {busy, fifo_count}, 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic frame_len(input int clocks, input string name);
    repeat (clocks) @(negedge clk);
    check({name, "_last"}, busy, 1);
    @(negedge clk);
    check({name, "_end"}, busy, 0);
  endtask
  initial begin : monitor
    frame_t f;
    bit prev_end, ok;
    int bad_c, nfr, w;
    logic bad_v;
    prev_end = 0;
    nfr = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || reset) begin
        prev_end = 0;
        continue;
      end
      if (prev_end && sb.size() > 0 && sb[0].b2b) check($sformatf("gap_before_frame%0d", nfr), TX, 0);
      prev_end = 0;
      if (TX === 1'b0) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start TX got=0 expected=1");
          w = 0;
          while (TX === 1'b0 && w < 2000) begin
            @(negedge clk);
            w++;
          end
        end else begin
          f = sb.pop_front();
          ok = 1;
          bad_c = 0;
          bad_v = 1'b0;
          for (int c = 0; c < f.len * f.div; c++) begin
            if (c > 0) @(negedge clk);
            if (ok && TX !== f.lv[c / f.div]) begin
              ok = 0;
              bad_c = c;
              bad_v = TX;
            end
          end
          checks++;
          if (!ok) begin
            failures++;
            $display("FAIL frame%0d clock %0d TX got=%b expected=%b", nfr, bad_c, bad_v, f.lv[bad_c / f.div]);
          end
          nfr++;
          prev_end = 1;
        end
      end
    end
  end
  initial begin
    bit ok;
    int n;
    checks = 0;
    failures = 0;
    mon_en = 1;
    reset = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    data_bits = 4'd8;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    baud_div = 16'd4;
    repeat (5) @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_tx", TX, 1);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_tx", TX, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_wr_ready", wr_ready, 1);
    check("post_rst_count", fifo_count, 0);
    send(8'hA5, 1, lit(16'b0101001011_000000, 10, 4, 0));
    check("lat_count1", fifo_count, 1);
    check("lat_tx_idle", TX, 1);
    @(negedge clk);
    check("lat_count0", fifo_count, 0);
    check("lat_tx_start", TX, 0);
    check("lat_busy", busy, 1);
    repeat (39) @(negedge clk);
    check("8n1_last_busy", busy, 1);
    check("8n1_last_tx", TX, 1);
    @(negedge clk);
    check("8n1_busy_drop", busy, 0);
    data_bits = 4'd7;
    parity_en = 1'b1;
    two_stop = 1'b1;
    send(8'h41, 1, lit(16'b01000001011_00000, 11, 4, 0));
    frame_len(44, "7e2_len");
    wait_idle(100, "idle_7e2");
    parity_odd = 1'b1;
    send(8'h41, 1, lit(16'b01000001111_00000, 11, 4, 0));
    frame_len(44, "7o2_len");
    wait_idle(100, "idle_7o2");
    data_bits = 4'd8;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    two_stop = 1'b0;
    baud_div = 16'd100;
    for (int i = 0; i < 20; i++) begin
      wr_data = 8'(i);
      wr_valid = 1'b1;
      check($sformatf("accept_%0d", i), wr_ready, i <= 16);
      if (wr_ready) sb.push_back(mk(9'(i), 8, 0, 0, 1, 100, i > 0));
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("full_count", fifo_count, 16);
    check("full_wr_ready", wr_ready, 0);
    n = 0;
    while (!wr_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("refill_ready", wr_ready, 1);
    check("refill_count", fifo_count, 15);
    wait_idle(20000, "idle_stream");
    baud_div = 16'd4;
    mon_en = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(8'h00, 0, lit('1, 10, 4, 0));
    check("queued3", fifo_count, 3);
    repeat (11) @(negedge clk);
    check("bit2_busy", busy, 1);
    check("bit2_tx", TX, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_tx", TX, 1);
    check("midrst_busy", busy, 0);
    check("midrst_count", fifo_count, 0);
    check("midrst_wr_ready", wr_ready, 0);
    reset = 1'b0;
    ok = 1;
    repeat (200) begin
      @(negedge clk);
      if (TX !== 1'b1 || busy !== 1'b0) ok = 0;
    end
    check("quiet_after_reset", ok, 1);
    mon_en = 1;
    send(8'hC3, 1, lit(16'b0110000111_000000, 10, 4, 0));
    send(8'h15, 1, lit(16'b0101011_000000000, 7, 2, 1));
    repeat (10) @(negedge clk);
    data_bits = 4'd3;
    baud_div = 16'd0;
    wait_idle(200, "idle_cfg");
    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
